// File: rtl/hazard_info_pipe.sv
// IF/ID instruction register, D-stage decode and E/M/W hazard-field pipeline.
// Optional stall counter: define HAZARD_STALL_CNT_EN to add Stall_Count.
module hazard_info_pipe #(
    parameter int JAL_REG = 31,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr_F,
    input  logic             IF_ID_EN,
    input  logic             ID_EXE_CLR,
`ifdef HAZARD_STALL_CNT_EN
    output logic [CNT_W-1:0] Stall_Count,
`endif
    output logic [31:0]      Instr_D,
    output logic [6:0]       D_InstrType,
    output logic [6:0]       E_InstrType,
    output logic [6:0]       M_InstrType,
    output logic [6:0]       W_InstrType,
    output logic [4:0]       RS_D,
    output logic [4:0]       RT_D,
    output logic [4:0]       RS_E,
    output logic [4:0]       RT_E,
    output logic [4:0]       RT_M,
    output logic [4:0]       RegWrite_E,
    output logic [4:0]       RegWrite_M,
    output logic [4:0]       RegWrite_W
);

    localparam logic [6:0] typeR     = 7'b0000001;
    localparam logic [6:0] typeI     = 7'b0000010;
    localparam logic [6:0] typeB     = 7'b0000100;
    localparam logic [6:0] typeStore = 7'b0001000;
    localparam logic [6:0] typeLoad  = 7'b0010000;
    localparam logic [6:0] typeJl    = 7'b0100000;
    localparam logic [6:0] typeJr    = 7'b1000000;
    localparam logic [4:0] jalReg    = 5'(JAL_REG);

    typedef struct packed {
        logic [6:0] instrType;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } exStage_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic       isSpecial;
    logic [4:0] dstD;
    exStage_t   exReg;
    exStage_t   exNext;
    logic [6:0] memType;
    logic [4:0] memRt;
    logic [4:0] memDst;
    logic [6:0] wbType;
    logic [4:0] wbDst;

    assign op        = Instr_D[31:26];
    assign funct     = Instr_D[5:0];
    assign isSpecial = (op == 6'b000000);
    assign RS_D      = Instr_D[25:21];
    assign RT_D      = Instr_D[20:16];

    always_comb begin
        D_InstrType = 7'b0000000;
        unique case (1'b1)
            isSpecial && (funct == 6'b100001 || funct == 6'b100011):
                D_InstrType = typeR;
            isSpecial && (funct == 6'b001000):
                D_InstrType = typeJr;
            op == 6'b001101 || op == 6'b001111:
                D_InstrType = typeI;
            op == 6'b000100:
                D_InstrType = typeB;
            op == 6'b101011:
                D_InstrType = typeStore;
            op == 6'b100011:
                D_InstrType = typeLoad;
            op == 6'b000011:
                D_InstrType = typeJl;
            default:
                D_InstrType = 7'b0000000;
        endcase
    end

    always_comb begin
        dstD = 5'd0;
        unique case (1'b1)
            D_InstrType[0]:                  dstD = Instr_D[15:11];
            D_InstrType[1] | D_InstrType[4]: dstD = Instr_D[20:16];
            D_InstrType[5]:                  dstD = jalReg;
            default:                         dstD = 5'd0;
        endcase
    end

    assign exNext = '{instrType: D_InstrType, rs: RS_D, rt: RT_D, dst: dstD};

    always_ff @(posedge clk) begin
        if (reset) begin
            Instr_D <= 32'd0;
            exReg   <= '0;
            memType <= 7'd0;
            memRt   <= 5'd0;
            memDst  <= 5'd0;
            wbType  <= 7'd0;
            wbDst   <= 5'd0;
        end else begin
            if (IF_ID_EN)
                Instr_D <= Instr_F;
            // E re-captures D when neither loading nor clearing: duplicate issue
            exReg   <= ID_EXE_CLR ? '0 : exNext;
            memType <= exReg.instrType;
            memRt   <= exReg.rt;
            memDst  <= exReg.dst;
            wbType  <= memType;
            wbDst   <= memDst;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            Stall_Count <= '0;
        else if (!IF_ID_EN && ID_EXE_CLR)
            Stall_Count <= Stall_Count + 1'b1;
    end
`endif

    assign E_InstrType = exReg.instrType;
    assign RS_E        = exReg.rs;
    assign RT_E        = exReg.rt;
    assign RegWrite_E  = exReg.dst;
    assign M_InstrType = memType;
    assign RT_M        = memRt;
    assign RegWrite_M  = memDst;
    assign W_InstrType = wbType;
    assign RegWrite_W  = wbDst;

endmodule

// File: tb/tb_hazard_info_pipe.sv
// Bench for hazard_info_pipe: directed plan steps plus random traffic
// against a model that tracks whole instruction words per stage.
module tb_hazard_info_pipe;

    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_F;
    logic        IF_ID_EN;
    logic        ID_EXE_CLR;
    logic [31:0] Instr_D;
    logic [6:0]  D_InstrType, E_InstrType, M_InstrType, W_InstrType;
    logic [4:0]  RS_D, RT_D, RS_E, RT_E, RT_M;
    logic [4:0]  RegWrite_E, RegWrite_M, RegWrite_W;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] mCnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mD, mE, mM, mW;

    always #5 clk = ~clk;

    hazard_info_pipe #(.JAL_REG(31), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .Instr_F(Instr_F),
        .IF_ID_EN(IF_ID_EN),
        .ID_EXE_CLR(ID_EXE_CLR),
`ifdef HAZARD_STALL_CNT_EN
        .Stall_Count(Stall_Count),
`endif
        .Instr_D(Instr_D),
        .D_InstrType(D_InstrType),
        .E_InstrType(E_InstrType),
        .M_InstrType(M_InstrType),
        .W_InstrType(W_InstrType),
        .RS_D(RS_D),
        .RT_D(RT_D),
        .RS_E(RS_E),
        .RT_E(RT_E),
        .RT_M(RT_M),
        .RegWrite_E(RegWrite_E),
        .RegWrite_M(RegWrite_M),
        .RegWrite_W(RegWrite_W)
    );

    // Instruction class by its mnemonic, straight from the ISA subset
    function automatic logic [6:0] typeOf(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] f;
        op = w[31:26];
        f  = w[5:0];
        if (w == 32'd0) return 7'd0;
        if (op == 6'd0 && (f == 6'h21 || f == 6'h23)) return 7'd1;
        if (op == 6'd0 && f == 6'h08) return 7'd64;
        if (op == 6'h0D || op == 6'h0F) return 7'd2;
        if (op == 6'h04) return 7'd4;
        if (op == 6'h2B) return 7'd8;
        if (op == 6'h23) return 7'd16;
        if (op == 6'h03) return 7'd32;
        return 7'd0;
    endfunction

    function automatic logic [4:0] dstOf(input logic [31:0] w);
        logic [6:0] t;
        t = typeOf(w);
        if (t == 7'd1) return w[15:11];
        if (t == 7'd2 || t == 7'd16) return w[20:16];
        if (t == 7'd32) return 5'd31;
        return 5'd0;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] b;
        b = $urandom;
        case ($urandom_range(0, 11))
            0:  return {6'h00, b[25:6], 6'h21};
            1:  return {6'h00, b[25:6], 6'h23};
            2:  return {6'h00, b[25:6], 6'h08};
            3:  return {6'h0D, b[25:0]};
            4:  return {6'h0F, b[25:0]};
            5:  return {6'h04, b[25:0]};
            6:  return {6'h2B, b[25:0]};
            7:  return {6'h23, b[25:0]};
            8:  return {6'h03, b[25:0]};
            9:  return {6'h02, b[25:0]};
            10: return 32'd0;
            default: return b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; the model sees the inputs that were stable before it
    task automatic tick();
        @(posedge clk);
        mW = reset ? 32'd0 : mM;
        mM = reset ? 32'd0 : mE;
        mE = (reset || ID_EXE_CLR) ? 32'd0 : mD;
        mD = reset ? 32'd0 : (IF_ID_EN ? Instr_F : mD);
`ifdef HAZARD_STALL_CNT_EN
        if (reset) mCnt = '0;
        else if (!IF_ID_EN && ID_EXE_CLR) mCnt = mCnt + 1'b1;
`endif
        #1;
    endtask

    task automatic checkAll();
        check("Instr_D", Instr_D, mD);
        check("D_type", 32'(D_InstrType), 32'(typeOf(mD)));
        check("E_type", 32'(E_InstrType), 32'(typeOf(mE)));
        check("M_type", 32'(M_InstrType), 32'(typeOf(mM)));
        check("W_type", 32'(W_InstrType), 32'(typeOf(mW)));
        check("RS_D", 32'(RS_D), 32'(mD[25:21]));
        check("RT_D", 32'(RT_D), 32'(mD[20:16]));
        check("RS_E", 32'(RS_E), 32'(mE[25:21]));
        check("RT_E", 32'(RT_E), 32'(mE[20:16]));
        check("RT_M", 32'(RT_M), 32'(mM[20:16]));
        check("RegWrite_E", 32'(RegWrite_E), 32'(dstOf(mE)));
        check("RegWrite_M", 32'(RegWrite_M), 32'(dstOf(mM)));
        check("RegWrite_W", 32'(RegWrite_W), 32'(dstOf(mW)));
`ifdef HAZARD_STALL_CNT_EN
        check("Stall_Count", 32'(Stall_Count), 32'(mCnt));
`endif
    endtask

    task automatic drive(input logic r, input logic [31:0] f,
                         input logic en, input logic clr);
        reset      = r;
        Instr_F    = f;
        IF_ID_EN   = en;
        ID_EXE_CLR = clr;
        tick();
        checkAll();
    endtask

    localparam logic [31:0] ADDU1 = 32'h00221821;
    localparam logic [31:0] LW    = 32'h8C850000;
    localparam logic [31:0] ADDU2 = 32'h00A53021;
    localparam logic [31:0] JAL   = 32'h0C000010;
    localparam logic [31:0] SW    = 32'hAD070004;
    localparam logic [31:0] ORI   = 32'h34220005;

    initial begin
        mD = 0; mE = 0; mM = 0; mW = 0;
`ifdef HAZARD_STALL_CNT_EN
        mCnt = '0;
`endif
        reset = 1'b1; Instr_F = 32'd0; IF_ID_EN = 1'b1; ID_EXE_CLR = 1'b0;
        #1;
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        check("nop_W_type", 32'(W_InstrType), 32'd0);
        check("nop_RegWrite_W", 32'(RegWrite_W), 32'd0);

        drive(0, ADDU1, 1, 0);
        check("addu_D_type", 32'(D_InstrType), 32'h01);
        check("addu_RS_D", 32'(RS_D), 32'd1);
        check("addu_RT_D", 32'(RT_D), 32'd2);
        drive(0, 0, 1, 0);
        check("addu_RegWrite_E", 32'(RegWrite_E), 32'd3);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        check("addu_W_type", 32'(W_InstrType), 32'h01);
        check("addu_RegWrite_W", 32'(RegWrite_W), 32'd3);

        drive(0, LW, 1, 0);
        drive(0, ADDU2, 1, 0);
        check("ld_use_D", Instr_D, ADDU2);
        drive(0, 0, 0, 1);
        check("ld_use_D_held", Instr_D, ADDU2);
        check("ld_use_E_bubble", 32'(E_InstrType), 32'd0);
        check("ld_use_M_load", 32'(M_InstrType), 32'h10);
        drive(0, 0, 1, 0);
        check("ld_use_E_addu", 32'(E_InstrType), 32'h01);
        check("ld_use_M_bubble", 32'(M_InstrType), 32'd0);

        drive(0, JAL, 1, 0);
        drive(0, SW, 1, 0);
        check("jal_E_type", 32'(E_InstrType), 32'h20);
        check("jal_RegWrite_E", 32'(RegWrite_E), 32'd31);
        drive(0, 0, 1, 0);
        check("sw_E_type", 32'(E_InstrType), 32'h08);
        check("sw_RegWrite_E", 32'(RegWrite_E), 32'd0);
        drive(0, 0, 1, 0);
        check("sw_RT_M", 32'(RT_M), 32'd7);

        drive(0, LW, 1, 0);
        drive(0, ORI, 1, 0);
        drive(1, ADDU1, 1, 0);
        check("rst_E_type", 32'(E_InstrType), 32'd0);
        check("rst_M_type", 32'(M_InstrType), 32'd0);
        check("rst_RegWrite_E", 32'(RegWrite_E), 32'd0);
        check("rst_Instr_D", Instr_D, 32'd0);

        drive(0, ADDU1, 1, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, LW, 1, 1);
        check("dual_ctl_D", Instr_D, LW);
        check("dual_ctl_E", 32'(E_InstrType), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt_3", 32'(Stall_Count), 32'd3);
        drive(1, 0, 0, 1);
        check("stall_cnt_rst", 32'(Stall_Count), 32'd0);
`endif
        drive(0, SW, 0, 0);
        drive(0, 0, 0, 0);
        check("dup_issue_E", 32'(E_InstrType), 32'h10);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 29) == 0), randInstr(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_info_pipe.md
Name: hazard_info_pipe

Overview:
- Source of every per-stage field that the stall and forward logic consumes.
- Holds the IF/ID instruction register and decodes the D-stage instruction into a one-hot type, RS/RT and destination register.
- Carries type, RS/RT and destination through E, M and W pipeline registers.
- Obeys the IF_ID_EN / ID_EXE_CLR controls that the stall logic returns.

Parameters:
- JAL_REG, 31: destination register written by jal.
- CNT_W, 32: width of the optional stall counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Instr_F  input  32  instruction fetched in F stage.
- IF_ID_EN  input  1  1 = D register loads Instr_F; 0 = D holds.
- ID_EXE_CLR  input  1  1 = E register loads a bubble instead of the D contents.
- Instr_D  output  32  current D-stage instruction.
- D_InstrType, E_InstrType, M_InstrType, W_InstrType  output  7  one-hot instruction type per stage.
- RS_D, RT_D  output  5  D-stage source registers (combinational from Instr_D).
- RS_E, RT_E  output  5  E-stage source registers.
- RT_M  output  5  M-stage rt.
- RegWrite_E, RegWrite_M, RegWrite_W  output  5  destination register per stage; 0 = no write.
- Stall_Count  output  CNT_W  only present with the optional feature.

Behaviour:
- Type encoding, one-hot:
  - R 7'b0000001, I 7'b0000010, B 7'b0000100, Store 7'b0001000, Load 7'b0010000, Jl 7'b0100000, Jr 7'b1000000.
  - Bubble / unrecognised = 7'b0000000.
- Decode of Instr_D (op = [31:26], funct = [5:0]):
  - Instr_D == 0 (nop) -> bubble.
  - op 000000, funct 100001 (addu) or 100011 (subu) -> R.
  - op 000000, funct 001000 -> Jr.
  - op 001101 (ori) or 001111 (lui) -> I.
  - op 000100 (beq) -> B.
  - op 101011 (sw) -> Store.
  - op 100011 (lw) -> Load.
  - op 000011 (jal) -> Jl.
  - op 000010 (j) and all others -> bubble.
- RS_D = Instr_D[25:21] and RT_D = Instr_D[20:16], unconditionally.
- D destination:
  - R -> rd [15:11].
  - I or Load -> rt.
  - Jl -> JAL_REG.
  - Otherwise 0.
- D register, each rising edge:
  - reset -> Instr_D = 0.
  - else IF_ID_EN = 1 -> Instr_D <= Instr_F.
  - else hold.
- E register, each edge:
  - reset or ID_EXE_CLR -> type 0, RS_E = 0, RT_E = 0, RegWrite_E = 0.
  - else load the D type, RS_D, RT_D and D destination.
- M register, each edge (never stalled):
  - reset -> all 0.
  - else load E_InstrType, RT_E, RegWrite_E.
- W register, each edge (never stalled):
  - reset -> all 0.
  - else load M_InstrType, RegWrite_M.
- Latency: an instruction appears at D one cycle after capture, then E, M and W on the following three edges.
- Outputs after reset: every output is 0 (all types bubble).
- Simultaneous controls:
  - IF_ID_EN = 0 with ID_EXE_CLR = 1 (normal stall): D holds, E gets a bubble, M and W advance.
  - IF_ID_EN = 1 with ID_EXE_CLR = 1: D loads and E gets a bubble.
  - IF_ID_EN = 0 with ID_EXE_CLR = 0: D holds and E re-captures the same D instruction (duplicate issue).
  - reset dominates both controls.
- Reset mid-stream: all in-flight stages are discarded on the same edge; no partial state is retained.
- RegWrite_* = 0 always means "no write"; destination 0 is never reported for a writing instruction except rd/rt = 0, which the consumer ignores.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- When defined:
  - Stall_Count port exists.
  - Counter increments by 1 on each edge where reset = 0, IF_ID_EN = 0 and ID_EXE_CLR = 1.
  - Cleared by reset; wraps modulo 2^CNT_W.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 edges of nop -> all type outputs 0, all RegWrite_* 0, Instr_D 0.
- Feed addu $3,$1,$2 (0x00221821), controls 1/0 -> D_InstrType 0000001 with RS_D 1, RT_D 2; RegWrite_E 3 at the next edge; W_InstrType 0000001 with RegWrite_W 3 three edges later.
- lw $5,0($4) followed by addu $6,$5,$5, with IF_ID_EN = 0 and ID_EXE_CLR = 1 for one cycle when addu is in D:
  - addu held in D for 2 cycles.
  - E_InstrType 0 for one cycle, then addu enters E.
  - M_InstrType shows Load then 0.
- jal (0x0C000010) -> E_InstrType 0100000, RegWrite_E 31; sw $7,4($8) -> type 0001000 with RegWrite_E 0 and RT_M 7.
- Assert reset while lw is in E and ori is in D -> next edge all types 0, RegWrite_E/M/W 0.
- With HAZARD_STALL_CNT_EN: 3 stall cycles, then 1 cycle with IF_ID_EN = 1 and ID_EXE_CLR = 1 -> Stall_Count = 3; after reset, Stall_Count = 0.
